vram_fill_engine: RTL and testbench
===================================

Name: vram_fill_engine

Overview:
- Memory-mapped rectangle-fill accelerator that sits directly upstream of vgadriver's VRAM write port.
- The CPU programs a word-aligned rectangle and a 32-bit fill pattern over IOBUS. The block then streams one VRAM write per cycle to vgadriver (xaddr/yaddr/data/wen).
- It also arbitrates the CPU's direct VRAM stores onto the same port, giving them priority.

Parameters:
- BASE_AD, 32'hFFFE0000, IOBUS base address of the register block (6 word registers).
- ROWS, 540, number of valid VRAM rows; rows at or above ROWS are clipped.
- COLS, 64, number of valid word columns (xaddr range); columns at or above COLS are clipped.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- io_wr  in  1  IOBUS write strobe
- io_addr  in  32  IOBUS address
- io_wdata  in  32  IOBUS write data
- io_rdata  out  32  register read data; combinational; 0 when io_addr is outside BASE_AD..BASE_AD+0x14
- cpu_wen  in  1  direct CPU VRAM write request
- cpu_xaddr  in  6  direct write word column
- cpu_yaddr  in  10  direct write row
- cpu_data  in  32  direct write data
- vblank  in  1  vertical-blank flag from vgadriver
- xaddr  out  6  VRAM write column (registered)
- yaddr  out  10  VRAM write row (registered)
- data  out  32  VRAM write data (registered)
- wen  out  1  VRAM write enable (registered)
- busy  out  1  fill in progress (includes WAIT_VB)
- done  out  1  one-cycle pulse after the last fill write

Behaviour:
- Register map, offsets from BASE_AD:
  - +0x00 X0[5:0]
  - +0x04 Y0[9:0]
  - +0x08 W[6:0]
  - +0x0C H[9:0]
  - +0x10 PATTERN[31:0]
  - +0x14 CTRL, write-only fields: bit0 start, bit1 wait_vblank, bit2 abort
  - Reads of +0x00..+0x10 return the zero-extended register. Read of +0x14 returns {31'b0, busy}.
- Register writes to +0x00..+0x10 while busy are ignored.
- Reset:
  - all registers 0; state IDLE
  - xaddr=0, yaddr=0, data=0, wen=0, busy=0, done=0
  - reset mid-fill abandons the fill immediately, with no further wen.
- Clipping (evaluated at start):
  - effW = 0 if X0>=COLS, else min(W, COLS-X0)
  - effH = 0 if Y0>=ROWS, else min(H, ROWS-Y0)
- States:
  - IDLE: on a CTRL write with start=1 and abort=0:
    - if effW==0 or effH==0, go to DONE (no writes).
    - else if wait_vblank=1, go to WAIT_VB.
    - else go to FILL, with cursor (cx,cy)=(X0,Y0).
  - WAIT_VB: stays until a rising edge of vblank. The edge detector is a registered vblank compared with the current vblank. On the edge, go to FILL. vblank already high at start does not count as an edge.
  - FILL:
    - Each cycle without cpu_wen, issue a write of (cx,cy,PATTERN).
    - Advance cx. At cx==X0+effW-1, wrap cx to X0 and increment cy.
    - After the write at (X0+effW-1, Y0+effH-1), go to DONE.
  - DONE: for one cycle, done=1; then go to IDLE.
  - busy = (state is WAIT_VB or FILL). busy=1 the cycle after the start write. busy=0 in DONE.
- Abort: a CTRL write with abort=1 in any state forces IDLE next cycle. No done pulse. Abort has priority over start in the same write.
- Output arbitration (outputs registered, 1-cycle latency):
  - If cpu_wen at cycle N, outputs at N+1 = cpu fields with wen=1. The fill cursor holds (no write lost, no duplicate).
  - Else if FILL at N, outputs at N+1 = fill write with wen=1.
  - Else wen=0 at N+1; xaddr/yaddr/data hold their last values.
- Throughput: an uncontended fill of effW*effH words takes effW*effH cycles. The first wen is 2 cycles after the start write (state transition + output register).
- A start write while busy is ignored unless abort=1.

Test Plan:
- Basic fill: X0=2, Y0=5, W=3, H=2, PATTERN=0xA5A5A5A5, start → exactly 6 wen pulses in order (2,5),(3,5),(4,5),(2,6),(3,6),(4,6). One done pulse the cycle after busy falls. busy high for 6 cycles.
- Contention: same fill with cpu_wen asserted (x=9, y=9, data=0x12345678) on the 3rd fill cycle → output sequence has the CPU write inserted at position 3. All 6 fill writes still occur exactly once; total 7 wen.
- Clipping: X0=62, W=5, Y0=538, H=4 (ROWS=540) → effW=2, effH=2. Writes only to (62,538),(63,538),(62,539),(63,539).
- Zero/out-of-range: W=0, start → no wen, busy never high, done pulse 1 cycle after the start write. Same result for X0=64.
- Vblank wait: start with wait_vblank=1 while vblank=1 → no writes until vblank falls then rises. First wen 2 cycles after the rising edge.
- Reset/abort: assert reset during the 3rd write of a 4x4 fill → wen=0, busy=0 next cycle, registers 0. Separately, a CTRL abort write mid-fill → IDLE, no done pulse, no further wen.

Source files
------------

// File: rtl/vram_fill_engine.sv
// -----------------------------------------------------------------------------
// vram_fill_engine
// Rectangle-fill accelerator placed in front of the VGA driver's VRAM write
// port. The CPU programs a word-aligned rectangle (X0, Y0, W, H) and a 32-bit
// pattern over IOBUS, then kicks it through CTRL. The engine streams one VRAM
// write per cycle. Direct CPU VRAM stores share the same port and always win;
// the fill cursor simply holds while a CPU store goes out.
//
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   io_wr/io_addr/io_wdata     IOBUS register write
//   io_rdata                   combinational register read data
//   cpu_wen/_xaddr/_yaddr/_data direct CPU VRAM store (priority)
//   vblank                     vertical-blank flag from the VGA driver
//   xaddr/yaddr/data/wen       registered VRAM write port
//   busy                       fill pending or running (WAIT_VB or FILL)
//   done                       one-cycle pulse after the final fill write
// -----------------------------------------------------------------------------
module vram_fill_engine #(
    parameter logic [31:0] BASE_AD = 32'hFFFE0000,
    parameter int          ROWS    = 540,
    parameter int          COLS    = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_wr,
    input  logic [31:0] io_addr,
    input  logic [31:0] io_wdata,
    output logic [31:0] io_rdata,
    input  logic        cpu_wen,
    input  logic [5:0]  cpu_xaddr,
    input  logic [9:0]  cpu_yaddr,
    input  logic [31:0] cpu_data,
    input  logic        vblank,
    output logic [5:0]  xaddr,
    output logic [9:0]  yaddr,
    output logic [31:0] data,
    output logic        wen,
    output logic        busy,
    output logic        done
);

    localparam logic [31:0] A_X0   = BASE_AD + 32'h0000_0000;
    localparam logic [31:0] A_Y0   = BASE_AD + 32'h0000_0004;
    localparam logic [31:0] A_W    = BASE_AD + 32'h0000_0008;
    localparam logic [31:0] A_H    = BASE_AD + 32'h0000_000C;
    localparam logic [31:0] A_PAT  = BASE_AD + 32'h0000_0010;
    localparam logic [31:0] A_CTRL = BASE_AD + 32'h0000_0014;

    localparam logic [6:0]  COLS_C = 7'(COLS);
    localparam logic [10:0] ROWS_C = 11'(ROWS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VB = 2'd1,
        ST_FILL    = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t      state_r, state_nx_s;

    // X0 keeps one extra bit so that a column of COLS or more can be
    // recognised and clipped to an empty rectangle instead of wrapping.
    logic [6:0]  x0_r;
    logic [9:0]  y0_r;
    logic [6:0]  w_r;
    logic [9:0]  h_r;
    logic [31:0] pattern_r;

    logic [5:0]  cx_r, x_end_r;
    logic [9:0]  cy_r, y_end_r;
    logic        vb_r;

    logic        reg_wr_s, ctrl_wr_s, abort_s, start_s;
    logic [6:0]  cols_left_s, eff_w_s;
    logic [10:0] rows_left_s, eff_h_s;
    logic        rect_empty_s;
    logic        fill_issue_s, load_cur_s, last_s;

    assign busy = (state_r == ST_WAIT_VB) || (state_r == ST_FILL);
    assign done = (state_r == ST_DONE);

    assign reg_wr_s  = io_wr && !busy;
    assign ctrl_wr_s = io_wr && (io_addr == A_CTRL);
    assign abort_s   = ctrl_wr_s && io_wdata[2];
    assign start_s   = ctrl_wr_s && io_wdata[0] && !io_wdata[2];

    // Clip the programmed rectangle against the VRAM bounds.
    always_comb begin
        cols_left_s = COLS_C - x0_r;
        rows_left_s = ROWS_C - {1'b0, y0_r};
        if (x0_r >= COLS_C) begin
            eff_w_s = 7'd0;
        end else if (w_r < cols_left_s) begin
            eff_w_s = w_r;
        end else begin
            eff_w_s = cols_left_s;
        end
        if ({1'b0, y0_r} >= ROWS_C) begin
            eff_h_s = 11'd0;
        end else if ({1'b0, h_r} < rows_left_s) begin
            eff_h_s = {1'b0, h_r};
        end else begin
            eff_h_s = rows_left_s;
        end
        rect_empty_s = (eff_w_s == 7'd0) || (eff_h_s == 11'd0);
    end

    assign last_s = (cx_r == x_end_r) && (cy_r == y_end_r);

    // Programmable registers; locked while a fill is pending or running.
    always_ff @(posedge clk) begin
        if (reset) begin
            x0_r      <= 7'd0;
            y0_r      <= 10'd0;
            w_r       <= 7'd0;
            h_r       <= 10'd0;
            pattern_r <= 32'd0;
        end else if (reg_wr_s) begin
            if (io_addr == A_X0)  x0_r      <= io_wdata[6:0];
            if (io_addr == A_Y0)  y0_r      <= io_wdata[9:0];
            if (io_addr == A_W)   w_r       <= io_wdata[6:0];
            if (io_addr == A_H)   h_r       <= io_wdata[9:0];
            if (io_addr == A_PAT) pattern_r <= io_wdata;
        end
    end

    // Register read-back mux; CTRL reads back the busy flag.
    always_comb begin
        case (io_addr)
            A_X0:    io_rdata = {25'd0, x0_r};
            A_Y0:    io_rdata = {22'd0, y0_r};
            A_W:     io_rdata = {25'd0, w_r};
            A_H:     io_rdata = {22'd0, h_r};
            A_PAT:   io_rdata = pattern_r;
            A_CTRL:  io_rdata = {31'd0, busy};
            default: io_rdata = 32'd0;
        endcase
    end

    // Previous vblank sample for rising-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            vb_r <= 1'b0;
        end else begin
            vb_r <= vblank;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic and fill-issue decision.
    always_comb begin
        state_nx_s   = state_r;
        fill_issue_s = 1'b0;
        load_cur_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    if (rect_empty_s) begin
                        state_nx_s = ST_DONE;
                    end else begin
                        load_cur_s = 1'b1;
                        state_nx_s = io_wdata[1] ? ST_WAIT_VB : ST_FILL;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WAIT_VB: begin
                if (abort_s) begin
                    state_nx_s = ST_IDLE;
                end else if (vblank && !vb_r) begin
                    state_nx_s = ST_FILL;
                end else begin
                    state_nx_s = ST_WAIT_VB;
                end
            end
            ST_FILL: begin
                // An abort in the same cycle suppresses this cycle's write so
                // nothing reaches VRAM after the abort.
                if (abort_s) begin
                    state_nx_s = ST_IDLE;
                end else if (cpu_wen) begin
                    state_nx_s = ST_FILL;
                end else begin
                    fill_issue_s = 1'b1;
                    state_nx_s   = last_s ? ST_DONE : ST_FILL;
                end
            end
            ST_DONE: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Fill cursor: loaded at start, advanced row-major on each issued write.
    always_ff @(posedge clk) begin
        if (reset) begin
            cx_r    <= 6'd0;
            cy_r    <= 10'd0;
            x_end_r <= 6'd0;
            y_end_r <= 10'd0;
        end else if (load_cur_s) begin
            cx_r    <= x0_r[5:0];
            cy_r    <= y0_r;
            x_end_r <= x0_r[5:0] + eff_w_s[5:0] - 6'd1;
            y_end_r <= y0_r + eff_h_s[9:0] - 10'd1;
        end else if (fill_issue_s) begin
            if (cx_r == x_end_r) begin
                cx_r <= x0_r[5:0];
                cy_r <= cy_r + 10'd1;
            end else begin
                cx_r <= cx_r + 6'd1;
            end
        end
    end

    // VRAM port register: CPU stores first, then fill writes, else idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            xaddr <= 6'd0;
            yaddr <= 10'd0;
            data  <= 32'd0;
            wen   <= 1'b0;
        end else if (cpu_wen) begin
            xaddr <= cpu_xaddr;
            yaddr <= cpu_yaddr;
            data  <= cpu_data;
            wen   <= 1'b1;
        end else if (fill_issue_s) begin
            xaddr <= cx_r;
            yaddr <= cy_r;
            data  <= pattern_r;
            wen   <= 1'b1;
        end else begin
            wen   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vram_fill_engine.sv
// -----------------------------------------------------------------------------
// tb_vram_fill_engine
// Self-checking bench for vram_fill_engine: a table of rectangle fills with
// hand-computed expectations, plus directed abort and reset sequences.
// -----------------------------------------------------------------------------
module tb_vram_fill_engine;

    localparam logic [31:0] BASE = 32'hFFFE0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        io_wr;
    logic [31:0] io_addr, io_wdata, io_rdata;
    logic        cpu_wen;
    logic [5:0]  cpu_xaddr;
    logic [9:0]  cpu_yaddr;
    logic [31:0] cpu_data;
    logic        vblank;
    logic [5:0]  xaddr;
    logic [9:0]  yaddr;
    logic [31:0] data;
    logic        wen, busy, done;

    int checks = 0;
    int errors = 0;

    vram_fill_engine dut (
        .clk(clk), .reset(reset),
        .io_wr(io_wr), .io_addr(io_addr), .io_wdata(io_wdata), .io_rdata(io_rdata),
        .cpu_wen(cpu_wen), .cpu_xaddr(cpu_xaddr), .cpu_yaddr(cpu_yaddr), .cpu_data(cpu_data),
        .vblank(vblank),
        .xaddr(xaddr), .yaddr(yaddr), .data(data), .wen(wen),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  x0;
        logic [9:0]  y0;
        logic [6:0]  w;
        logic [9:0]  h;
        logic [31:0] pat;
        logic        wait_vb;
        logic        vb_init;
        int          vb_fall;
        int          vb_rise;
        int          cpu_k;
        int          x_lo, x_hi, y_lo, y_hi;
        int          ex_cnt, ex_busy, ex_first, ex_done;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic io_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        io_wr = 1'b1; io_addr = a; io_wdata = d;
        @(posedge clk);
        #1;
        io_wr = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        io_addr = a;
        #1;
        d = io_rdata;
    endtask

    task automatic program_rect(input logic [6:0] x0, input logic [9:0] y0,
                                input logic [6:0] w, input logic [9:0] h,
                                input logic [31:0] pat);
        io_write(BASE + 32'h00, {25'd0, x0});
        io_write(BASE + 32'h04, {22'd0, y0});
        io_write(BASE + 32'h08, {25'd0, w});
        io_write(BASE + 32'h0C, {22'd0, h});
        io_write(BASE + 32'h10, pat);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [47:0] got[$];
        logic [47:0] ex[$];
        int busy_cnt, done_cnt, done_k, first_k;
        busy_cnt = 0; done_cnt = 0; done_k = -1; first_k = -1;
        program_rect(v.x0, v.y0, v.w, v.h, v.pat);
        vblank = v.vb_init;
        io_write(BASE + 32'h14, {30'd0, v.wait_vb, 1'b1});
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (wen) begin
                got.push_back({xaddr, yaddr, data});
                if (first_k < 0) first_k = k;
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_k = k;
            end
            if (k == v.cpu_k) begin
                cpu_wen = 1'b1; cpu_xaddr = 6'd9; cpu_yaddr = 10'd9; cpu_data = 32'h12345678;
            end else begin
                cpu_wen = 1'b0;
            end
            if (k == v.vb_fall) vblank = 1'b0;
            if (k == v.vb_rise) vblank = 1'b1;
        end
        vblank = 1'b0;
        for (int y = v.y_lo; y <= v.y_hi; y++)
            for (int x = v.x_lo; x <= v.x_hi; x++)
                ex.push_back({6'(x), 10'(y), v.pat});
        if (v.cpu_k > 0) ex.insert(v.cpu_k - 1, {6'd9, 10'd9, 32'h12345678});
        chk($sformatf("v%0d_wen_count", idx), 64'(got.size()), 64'(v.ex_cnt));
        for (int i = 0; i < ex.size() && i < got.size(); i++)
            chk($sformatf("v%0d_write%0d", idx, i), {16'd0, got[i]}, {16'd0, ex[i]});
        chk($sformatf("v%0d_busy_cycles", idx), 64'(busy_cnt), 64'(v.ex_busy));
        chk($sformatf("v%0d_done_pulses", idx), 64'(done_cnt), 64'd1);
        chk($sformatf("v%0d_done_cycle", idx), 64'(done_k), 64'(v.ex_done));
        chk($sformatf("v%0d_first_wen", idx), 64'(first_k), 64'(v.ex_first));
    endtask

    initial begin
        logic [31:0] rv;
        int pre, post, dcnt;

        //           x0     y0       w     h       pat           wv    vi    fall rise cpu xlo xhi ylo  yhi  cnt busy first done
        tbl[0] = '{7'd2,  10'd5,   7'd3, 10'd2, 32'hA5A5A5A5, 1'b0, 1'b0, 0, 0, 0, 2,  4,  5,   6,   6, 6,  2,  7};
        tbl[1] = '{7'd2,  10'd5,   7'd3, 10'd2, 32'hA5A5A5A5, 1'b0, 1'b0, 0, 0, 3, 2,  4,  5,   6,   7, 7,  2,  8};
        tbl[2] = '{7'd62, 10'd538, 7'd5, 10'd4, 32'h0F0F0F0F, 1'b0, 1'b0, 0, 0, 0, 62, 63, 538, 539, 4, 4,  2,  5};
        tbl[3] = '{7'd1,  10'd1,   7'd0, 10'd3, 32'h33333333, 1'b0, 1'b0, 0, 0, 0, 0, -1,  0,  -1,  0, 0, -1,  1};
        tbl[4] = '{7'd64, 10'd0,   7'd3, 10'd2, 32'h44444444, 1'b0, 1'b0, 0, 0, 0, 0, -1,  0,  -1,  0, 0, -1,  1};
        tbl[5] = '{7'd0,  10'd540, 7'd1, 10'd1, 32'h55555555, 1'b0, 1'b0, 0, 0, 0, 0, -1,  0,  -1,  0, 0, -1,  1};
        tbl[6] = '{7'd10, 10'd20,  7'd2, 10'd1, 32'hCAFEF00D, 1'b1, 1'b1, 5, 7, 0, 10, 11, 20,  20,  2, 9,  9, 10};
        tbl[7] = '{7'd60, 10'd100, 7'd10,10'd1, 32'h77777777, 1'b0, 1'b0, 0, 0, 0, 60, 63, 100, 100, 4, 4,  2,  5};
        tbl[8] = '{7'd0,  10'd0,   7'd1, 10'd1, 32'h88888888, 1'b0, 1'b0, 0, 0, 0, 0,  0,  0,   0,   1, 1,  2,  2};

        reset = 1'b1; io_wr = 1'b0; io_addr = 32'd0; io_wdata = 32'd0;
        cpu_wen = 1'b0; cpu_xaddr = 6'd0; cpu_yaddr = 10'd0; cpu_data = 32'd0; vblank = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        chk("rst_wen", {63'd0, wen}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_port", {16'd0, xaddr, yaddr, data}, 64'd0);
        for (int i = 0; i < 6; i++) begin
            rd(BASE + 32'(i * 4), rv);
            chk($sformatf("rst_reg%0d", i), {32'd0, rv}, 64'd0);
        end

        // Read-back and out-of-range decode
        program_rect(7'd5, 10'd300, 7'd40, 10'd7, 32'hDEADBEEF);
        @(negedge clk);
        rd(BASE + 32'h00, rv); chk("rd_x0", {32'd0, rv}, 64'd5);
        rd(BASE + 32'h04, rv); chk("rd_y0", {32'd0, rv}, 64'd300);
        rd(BASE + 32'h08, rv); chk("rd_w", {32'd0, rv}, 64'd40);
        rd(BASE + 32'h10, rv); chk("rd_pat", {32'd0, rv}, 64'hDEADBEEF);
        rd(BASE + 32'h18, rv); chk("rd_oob", {32'd0, rv}, 64'd0);

        for (int i = 0; i < 9; i++) run_vec(i, tbl[i]);

        // Abort mid-fill; a register write while busy is ignored
        program_rect(7'd0, 10'd0, 7'd4, 10'd4, 32'h11111111);
        io_write(BASE + 32'h14, 32'd1);
        pre = 0; dcnt = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (wen) pre++;
            if (done) dcnt++;
            if (k == 4) chk("abort_busy", {63'd0, busy}, 64'd0);
            if (k == 1) begin
                rd(BASE + 32'h14, rv);
                chk("ctrl_rd_busy", {32'd0, rv}, 64'd1);
            end
            if (k == 2) begin
                io_wr = 1'b1; io_addr = BASE; io_wdata = 32'd30;
            end else if (k == 3) begin
                io_wr = 1'b1; io_addr = BASE + 32'h14; io_wdata = 32'd4;
            end else begin
                io_wr = 1'b0;
            end
        end
        chk("abort_wen_count", 64'(pre), 64'd2);
        chk("abort_no_done", 64'(dcnt), 64'd0);
        rd(BASE + 32'h00, rv);
        chk("busy_write_ignored", {32'd0, rv}, 64'd0);

        // Synchronous reset during the third write of a 4x4 fill
        program_rect(7'd0, 10'd0, 7'd4, 10'd4, 32'h22222222);
        io_write(BASE + 32'h14, 32'd1);
        pre = 0; post = 0; dcnt = 0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (wen && k <= 4) pre++;
            if (wen && k > 4) post++;
            if (done) dcnt++;
            if (k == 5) begin
                chk("rst_mid_wen", {63'd0, wen}, 64'd0);
                chk("rst_mid_busy", {63'd0, busy}, 64'd0);
                chk("rst_mid_xaddr", {58'd0, xaddr}, 64'd0);
                reset = 1'b0;
            end
            if (k == 4) reset = 1'b1;
        end
        chk("rst_mid_pre_writes", 64'(pre), 64'd3);
        chk("rst_mid_post_writes", 64'(post), 64'd0);
        chk("rst_mid_no_done", 64'(dcnt), 64'd0);
        rd(BASE + 32'h08, rv); chk("rst_mid_w", {32'd0, rv}, 64'd0);
        rd(BASE + 32'h10, rv); chk("rst_mid_pat", {32'd0, rv}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
